// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types and widths for the I2C transaction arbiter
package i2c_arb_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, FINISH} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant, searching upward from ptr with wrap
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic                    any
);
  logic [NREQ-1:0] rot, low;
  // rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back
  assign rot = NREQ'({req, req} >> ptr);
  assign low = rot & (-rot);
  assign gnt = NREQ'(({low, low} << ptr) >> NREQ);
  assign any = |req;
endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin scheduler sharing one i2c_controller master among NREQ requesters
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [I2C_ADDR_W*NREQ-1:0]   req_addr,
  input  logic [I2C_DATA_W*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]              req_rw,
  output logic [NREQ-1:0]              done,
  output logic [I2C_DATA_W-1:0]        rsp_data,
  output logic                         rsp_err,
  output logic                         busy,
  output logic                         m_enable,
  output logic [I2C_ADDR_W-1:0]        m_addr,
  output logic [I2C_DATA_W-1:0]        m_data,
  output logic                         m_rw,
  input  logic                         m_ready,
  input  logic [I2C_DATA_W-1:0]        m_rdata
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = I2C_ADDR_W + I2C_DATA_W + 1 + PW;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  state_t state;
  logic [1:0] sync;
  logic rdy_s, any, to, fin, fin_err, s_rw;
  logic [PW-1:0] ptr, s_idx;
  logic [NREQ-1:0] gnt, gnt_q;
  logic [TW-1:0] tmr;
  logic [I2C_ADDR_W-1:0] s_addr;
  logic [I2C_DATA_W-1:0] s_data;
  logic [SW-1:0] sc [NREQ+1];
  rr_arbiter #(.NREQ(NREQ)) u_rr (.req(req), .ptr(ptr), .gnt(gnt), .any(any));
  // one-hot AND-OR mux of the winner's fields and index
  assign sc[0] = '0;
  for (genvar i = 0; i < NREQ; i++) begin : g_sel
    assign sc[i+1] = sc[i] | (gnt[i] ? {req_addr[I2C_ADDR_W*i +: I2C_ADDR_W],
                                         req_data[I2C_DATA_W*i +: I2C_DATA_W],
                                         req_rw[i], PW'(i)} : SW'(0));
  end
  assign {s_addr, s_data, s_rw, s_idx} = sc[NREQ];
  assign rdy_s = sync[1];
  assign busy = state != IDLE;
  assign to = tmr == TMAX;
  // an accept already seen in ISSUE takes priority over a simultaneous timeout
  assign fin = (state == ISSUE && rdy_s && to) || (state == WAIT_DONE && (rdy_s || to));
  assign fin_err = !(state == WAIT_DONE && rdy_s);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync     <= '0;
      state    <= IDLE;
      ptr      <= '0;
      gnt_q    <= '0;
      tmr      <= '0;
      done     <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      m_enable <= 1'b0;
      m_addr   <= '0;
      m_data   <= '0;
      m_rw     <= 1'b0;
    end else begin
      sync <= {sync[0], m_ready};
      done <= '0;
      tmr  <= to ? tmr : tmr + TW'(1);
      if (fin) begin
        state    <= FINISH;
        tmr      <= '0;
        m_enable <= 1'b0;
        done     <= gnt_q;
        rsp_err  <= fin_err;
        if (m_rw) rsp_data <= m_rdata;
      end else if (state == IDLE && any && rdy_s) begin
        state    <= ISSUE;
        tmr      <= '0;
        m_enable <= 1'b1;
        m_addr   <= s_addr;
        m_data   <= s_data;
        m_rw     <= s_rw;
        gnt_q    <= gnt;
        ptr      <= s_idx == PW'(NREQ - 1) ? '0 : s_idx + PW'(1);
      end else if (state == ISSUE && !rdy_s) begin
        state <= WAIT_DONE;
        tmr   <= '0;
      end else if (state == FINISH) begin
        state <= IDLE;
        tmr   <= '0;
      end
    end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: directed table, corner sequences and randomized scoreboard run for i2c_txn_arbiter
module tb_i2c_txn_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0;
  logic [6:0] sa [4];
  logic [7:0] sd [4];
  logic [3:0] sr = '0;
  logic [27:0] req_addr;
  logic [31:0] req_data;
  logic [3:0] done;
  logic [7:0] rsp_data, m_data, m_rdata = '0, mdl_rdata = '0;
  logic rsp_err, busy, m_enable, m_rw, m_ready;
  logic [6:0] m_addr;
  logic mdl_ready = 1'b1, mdl_force = 1'b0;
  int mdl_low = 4;
  logic [3:0] t_req = '0, t_done;
  logic t_ready = 1'b1, t_rsp_err, t_busy, t_en, t_rw;
  logic [7:0] t_rsp_data, t_data;
  logic [6:0] t_addr;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  assign req_addr = {sa[3], sa[2], sa[1], sa[0]};
  assign req_data = {sd[3], sd[2], sd[1], sd[0]};
  assign m_ready = mdl_ready & ~mdl_force;
  i2c_txn_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data), .req_rw(sr),
    .done(done), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .m_enable(m_enable),
    .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw), .m_ready(m_ready), .m_rdata(m_rdata)
  );
  i2c_txn_arbiter #(.NREQ(4), .TIMEOUT(15)) dut_to (
    .clk(clk), .rst(rst), .req(t_req), .req_addr(28'h0ABCDEF), .req_data(32'h12345678), .req_rw(4'b0000),
    .done(t_done), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err), .busy(t_busy), .m_enable(t_en),
    .m_addr(t_addr), .m_data(t_data), .m_rw(t_rw), .m_ready(t_ready), .m_rdata(8'h99)
  );
  // master model: accept on enable, hold ready low mdl_low cycles, return data, wait for enable to drop
  initial forever begin
    @(negedge clk);
    if (m_enable && m_ready) begin
      #1 mdl_ready = 1'b0;
      repeat (mdl_low) @(negedge clk);
      #1 m_rdata = mdl_rdata;
      mdl_ready = 1'b1;
      for (int k = 0; k < 50 && m_enable; k++) @(negedge clk);
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask
  task automatic set_req(input logic [1:0] i, input logic [6:0] a, input logic [7:0] d, input logic rw);
    sa[i] = a;
    sd[i] = d;
    sr = rw ? sr | (4'b1 << i) : sr & ~(4'b1 << i);
    req = req | (4'b1 << i);
  endtask
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[2'((p + k) % 4)]) return (p + k) % 4;
    return -1;
  endfunction
  typedef struct {
    logic [1:0] idx;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       rw;
    logic [7:0] rdata;
    int         low;
    logic [3:0] exp_done;
    logic [7:0] exp_rsp;
  } vec_t;
  task automatic run_one(input vec_t v);
    int n;
    @(negedge clk);
    mdl_low = v.low;
    mdl_rdata = v.rdata;
    set_req(v.idx, v.addr, v.wdata, v.rw);
    @(posedge clk); #1;
    check("grant_latency", m_enable, 1);
    check("latched_addr", m_addr, v.addr);
    check("latched_data", m_data, v.wdata);
    check("latched_rw", m_rw, v.rw);
    n = 0;
    while (m_ready && n < 10) begin @(negedge clk); #2; n++; end
    check("master_accepted", m_ready, 0);
    n = 0;
    while (!m_ready && n < 300) begin @(negedge clk); #2; n++; end
    check("addr_stable", m_addr, v.addr);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (done == 0 && n < 20);
    check("done_latency", n, 3);
    check("done_onehot", done, v.exp_done);
    check("rsp_data", rsp_data, v.exp_rsp);
    check("rsp_err", rsp_err, 0);
    check("enable_low_at_done", m_enable, 0);
    @(negedge clk);
    req = '0;
    n = 0;
    repeat (4) begin @(posedge clk); #1; if (done != 0) n++; end
    check("single_done_pulse", n, 0);
    check("idle_after", busy, 0);
  endtask
  initial begin
    vec_t vecs [5];
    int n, w, cur, ref_ptr, grants;
    logic open, en_seen, en_prev;
    logic [7:0] exp_rsp, txn_rdata;
    vecs[0] = '{2'd0, 7'h2A, 8'hA5, 1'b0, 8'h11, 40, 4'b0001, 8'h00};
    vecs[1] = '{2'd2, 7'h2A, 8'h00, 1'b1, 8'hCC, 10, 4'b0100, 8'hCC};
    vecs[2] = '{2'd1, 7'h55, 8'h3C, 1'b0, 8'h77, 5,  4'b0010, 8'hCC};
    vecs[3] = '{2'd3, 7'h7F, 8'hFF, 1'b1, 8'h5A, 3,  4'b1000, 8'h5A};
    vecs[4] = '{2'd0, 7'h00, 8'h00, 1'b1, 8'h00, 1,  4'b0001, 8'h00};
    for (int i = 0; i < 4; i++) begin sa[2'(i)] = '0; sd[2'(i)] = '0; end
    #12;
    check("rst_done", done, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_enable", m_enable, 0);
    check("rst_mbus", {m_addr, m_data, m_rw}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) run_one(vecs[i]);
    // master not ready in IDLE: no grant; request withdrawn before any grant is ignored
    @(negedge clk);
    mdl_force = 1'b1;
    repeat (3) @(negedge clk);
    set_req(2'd3, 7'h33, 8'h44, 1'b0);
    en_seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; en_seen |= m_enable | busy; end
    check("no_grant_not_ready", en_seen, 0);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    mdl_force = 1'b0;
    repeat (8) begin @(posedge clk); #1; en_seen |= m_enable | busy; end
    check("withdrawn_ignored", en_seen, 0);
    // request withdrawn after grant still completes
    @(negedge clk);
    mdl_low = 6;
    set_req(2'd1, 7'h21, 8'h5E, 1'b0);
    @(posedge clk); #1;
    check("withdraw_grant", m_enable, 1);
    @(negedge clk);
    req = '0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (done == 0 && n < 100);
    check("withdraw_done", done, 4'b0010);
    // reset while waiting on the master
    repeat (3) @(negedge clk);
    mdl_low = 40;
    set_req(2'd2, 7'h12, 8'h34, 1'b1);
    n = 0;
    while (m_ready && n < 10) begin @(negedge clk); #2; n++; end
    repeat (10) @(negedge clk);
    check("pre_reset_enable", m_enable, 1);
    #3 rst = 1'b1;
    #1;
    check("async_reset_enable", m_enable, 0);
    check("async_reset_busy", busy, 0);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (60) begin @(posedge clk); #1; if (done != 0) n++; end
    check("no_done_after_reset", n, 0);
    // contention with all four held: order proves the pointer restarted at 0
    @(negedge clk);
    mdl_low = 4;
    for (int i = 0; i < 4; i++) set_req(2'(i), 7'(8'h10 + i), 8'(8'hE0 + i), 1'b0);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (done == 0 && n < 200);
      check("rr_order", done, 4'b1 << (k % 4));
      check("rr_addr", m_addr, 7'(8'h10 + k % 4));
    end
    @(negedge clk);
    req = '0;
    repeat (20) @(negedge clk);
    // randomized run against the round-robin scoreboard, starting from reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_ptr = 0;
    open = 1'b0;
    en_prev = 1'b0;
    exp_rsp = 8'h00;
    txn_rdata = 8'h00;
    cur = 0;
    grants = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk); #1;
      if (m_enable && !en_prev) begin
        w = rr_pick(req, ref_ptr);
        check("rnd_req_pending", w >= 0, 1);
        check("rnd_no_overlap", open, 0);
        if (w >= 0) begin
          check("rnd_grant_fields", {m_addr, m_data, m_rw}, {sa[2'(w)], sd[2'(w)], sr[2'(w)]});
          cur = w;
          ref_ptr = (w + 1) % 4;
        end
        open = 1'b1;
        grants++;
        mdl_low = $urandom_range(1, 12);
        mdl_rdata = 8'($urandom);
        txn_rdata = mdl_rdata;
      end
      if (done != 0) begin
        check("rnd_done", done, 4'b1 << cur);
        check("rnd_done_open", open, 1);
        if (sr[2'(cur)]) exp_rsp = txn_rdata;
        check("rnd_rsp_data", rsp_data, exp_rsp);
        check("rnd_rsp_err", rsp_err, 0);
        open = 1'b0;
      end
      en_prev = m_enable;
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (done[2'(i)]) req = req & ~(4'b1 << i);
        else if (cyc < 4000 && !req[2'(i)] && $urandom_range(0, 3) == 0)
          set_req(2'(i), 7'($urandom), 8'($urandom), 1'($urandom));
      if (cyc >= 4000 && req == 0 && !busy && !open) break;
    end
    check("rnd_drained", {req, busy, open}, 0);
    check("rnd_enough_grants", grants > 50, 1);
    // timeout instance: master never accepts
    @(negedge clk);
    t_req = 4'b0010;
    n = 0;
    while (!t_en && n < 10) begin @(posedge clk); #1; n++; end
    check("to_grant", t_en, 1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (t_done == 0 && n < 40);
    check("to_accept_latency", n >= 16 && n <= 17, 1);
    check("to_accept_done", t_done, 4'b0010);
    check("to_accept_err", t_rsp_err, 1);
    check("to_accept_enable", t_en, 0);
    @(negedge clk);
    t_req = '0;
    // master accepts but never finishes
    repeat (2) @(negedge clk);
    t_req = 4'b0001;
    n = 0;
    while (!t_en && n < 10) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    t_ready = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (t_done == 0 && n < 60);
    check("to_wait_latency", n, 19);
    check("to_wait_done", t_done, 4'b0001);
    check("to_wait_err", t_rsp_err, 1);
    @(negedge clk);
    t_req = '0;
    t_ready = 1'b1;
    // normal completion on the same instance clears the error
    repeat (4) @(negedge clk);
    t_req = 4'b0100;
    n = 0;
    while (!t_en && n < 10) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    t_ready = 1'b0;
    repeat (3) @(negedge clk);
    t_ready = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (t_done == 0 && n < 30);
    check("to_ok_done", t_done, 4'b0100);
    check("to_ok_err", t_rsp_err, 0);
    @(negedge clk);
    t_req = '0;
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
